// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one combinational ALU
//
// One transaction is in flight at a time: IDLE (grant) -> EXEC (ALU evaluates
// registered operands) -> RESP (hold response until consumed).
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins a tie
// instead of round-robin.

module alu_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_srca,
  input  logic [DATA_WIDTH-1:0]    req0_srcb,
  input  logic [OPCODE_LENGTH-1:0] req0_alucc,

  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_srca,
  input  logic [DATA_WIDTH-1:0]    req1_srcb,
  input  logic [OPCODE_LENGTH-1:0] req1_alucc,

  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_alucc,
  input  logic [DATA_WIDTH-1:0]    alu_result,

  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [DATA_WIDTH-1:0]    rsp_result,
  output logic                     rsp_err,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OPCODE_LENGTH-1:0] CC_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] CC_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] CC_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] CC_SUB = OPCODE_LENGTH'(4'b0110);

  state_t                   state;
  state_t                   state_nxt;
  logic [DATA_WIDTH-1:0]    opa_q;
  logic [DATA_WIDTH-1:0]    opb_q;
  logic [OPCODE_LENGTH-1:0] opcc_q;
  logic                     any_valid;
  logic                     grant_id;
  logic                     grant_en;
  logic                     legal_cc;

  assign any_valid = req0_valid | req1_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it is valid; requester 1 only when alone.
  assign grant_id = ~req0_valid;
`else
  logic last_grant;

  // On a tie the requester that did not win last time goes next; a lone
  // requester wins regardless of history.
  assign grant_id = (req0_valid & req1_valid) ? ~last_grant : ~req0_valid;

  // Remember the winner of every grant; reset value 1 lets requester 0 win
  // the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (grant_en) begin
      last_grant <= grant_id;
    end
  end
`endif

  // Only the four defined operations produce a result; anything else errors.
  assign legal_cc = (opcc_q == CC_AND) || (opcc_q == CC_OR) ||
                    (opcc_q == CC_ADD) || (opcc_q == CC_SUB);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; grants only happen in IDLE, so a
  // response accepted in RESP can never overlap with a new grant.
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          grant_en  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant_en & ~grant_id;
  assign req1_ready = grant_en &  grant_id;
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == RESP);

  // Latch the granted requester's payload and id; the ALU is fed from these
  // registers so its inputs hold steady through EXEC and afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q  <= '0;
      opb_q  <= '0;
      opcc_q <= '0;
      rsp_id <= 1'b0;
    end else if (grant_en) begin
      opa_q  <= grant_id ? req1_srca  : req0_srca;
      opb_q  <= grant_id ? req1_srcb  : req0_srcb;
      opcc_q <= grant_id ? req1_alucc : req0_alucc;
      rsp_id <= grant_id;
    end
  end

  assign alu_srca  = opa_q;
  assign alu_srcb  = opb_q;
  assign alu_alucc = opcc_q;

  // Capture the ALU output at the end of EXEC; illegal codes return zero
  // with the error flag so the consumer never sees a garbage result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_result <= legal_cc ? alu_result : '0;
      rsp_err    <= ~legal_cc;
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` datapath between two requesters (e.g. the integer execute stage and the branch/address unit). Each requester presents operands and an ALU control code with a valid/ready handshake; the arbiter grants one per transaction, drives the ALU from registered operands, captures the result and returns it on a shared response channel tagged with the requester id. One transaction is in flight at a time.

## Interface
- `DATA_WIDTH`, 64, operand/result width; matches the ALU.
- `OPCODE_LENGTH`, 4, ALU control code width.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester has an operation pending.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_srca`, `req0_srcb` / `req1_srca`, `req1_srcb`  in  DATA_WIDTH  operands.
- `req0_alucc` / `req1_alucc`  in  OPCODE_LENGTH  ALU control code.
- `alu_srca`, `alu_srcb`  out  DATA_WIDTH  to ALU `SrcA`/`SrcB`.
- `alu_alucc`  out  OPCODE_LENGTH  to ALU `ALUCC`.
- `alu_result`  in  DATA_WIDTH  from ALU `ALUResult`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer accepts.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_result`  out  DATA_WIDTH  captured result; 0 on error.
- `rsp_err`  out  1  illegal control code.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any `reqN_valid`, grant one. `reqN_ready` is asserted combinationally for the granted requester only, only in IDLE. On that edge, latch srca/srcb/alucc into operand registers, record `rsp_id`, go EXEC. No valid: stay IDLE.
- Legal control codes: 4'b0000 AND, 4'b0001 OR, 4'b0010 ADD, 4'b0110 SUB. Any other code is illegal.
- EXEC: `alu_*` outputs are driven from the operand registers at all times (they hold the last operands outside EXEC). At the end of the single EXEC cycle, capture `alu_result` into `rsp_result` with `rsp_err`=0. For an illegal code, capture 0 with `rsp_err`=1. Then go RESP.
- RESP: `rsp_valid`=1 and `rsp_*` held stable until `rsp_ready`=1. On the accepting edge, go IDLE. No new grant occurs in the same cycle as response acceptance.
- Arbitration uses round-robin. A `last_grant` register is updated on each grant. When both requesters are valid, the one not in `last_grant` wins. When only one is valid, it wins regardless.
- A requester must hold valid and its payload until ready. A request dropped before grant is simply not served.

## Timing
- Reset values (async, immediate): state IDLE, all `reqN_ready` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_result` 0, `rsp_err` 0, `busy` 0, operand registers and `alu_*` 0, `last_grant` 1 (requester 0 wins first tie).
- Accept at edge N → EXEC during cycle N+1 → `rsp_valid` high from cycle N+2. Minimum 3 cycles per transaction with `rsp_ready` tied high. Throughput is one transaction per 3 cycles.
- Reset asserted mid-transaction: the transaction is discarded with no response. Arbitration restarts with requester 0 priority.
- Simultaneous `rsp_ready` and new `reqN_valid` in RESP: the response completes. The new request is granted no earlier than the following IDLE cycle.
- The ALU is combinational, so its result is settled within the EXEC cycle.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: fixed priority; requester 0 always wins when both are valid, and `last_grant` is unused.
- Not defined: round-robin as above.

## Test plan
- Reset, then req0 ADD srca=5, srcb=7 alone → `req0_ready` pulses cycle 0; `alu_alucc`=0010 in cycle 1; `rsp_valid`=1, `rsp_id`=0, `rsp_result`=12, `rsp_err`=0 in cycle 2.
- req0 and req1 held valid continuously (req0 SUB 10−3, req1 OR 0xF0|0x0F), `rsp_ready`=1 → grants alternate 0,1,0,1. Responses are 7 (id 0) and 0xFF (id 1). With `ALU_ARB_FIXED_PRIO_EN`, only id 0 is served.
- req1 alucc=4'b0011 → `rsp_err`=1, `rsp_result`=0, `rsp_id`=1.
- `rsp_ready` held 0 for 5 cycles in RESP with AND 0xFF&0x0F → `rsp_valid` and `rsp_result`=0x0F stable. No `reqN_ready` while stalled. IDLE follows acceptance.
- `rst_n` pulsed low during EXEC → `rsp_valid` never rises for that transaction. All outputs are 0 immediately. The next tie is granted to requester 0.
- SUB 0−1 → `rsp_result`=64'hFFFF_FFFF_FFFF_FFFF (wrap-around, no overflow flag).
